qacc: RTL and testbench
=======================

# qacc

Sequential signed fixed-point accumulator that sits directly downstream of the 32-bit Q-format multiplier in the Kalman datapath. It consumes one product per cycle over a valid/ready handshake and sums the terms of one dot product (matrix row × vector) with saturation. It presents the finished sum, a sticky overflow flag and a term count to the next stage.

## Interface
- Q, default 18: fraction bits of the input and output words; must match the multiplier.
- N, default 32: total word width, signed two's complement.
- MAXLEN, default 8: maximum number of terms per dot product.
- CW, default 4: count width, clog2(MAXLEN+1).
- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: a product term is present.
- in_ready, output, 1: the block accepts a term this cycle.
- in_data, input, N: signed Q-format product from the multiplier.
- in_ovr, input, 1: multiplier overflow flag for this term.
- in_last, input, 1: this term is the final term of the vector.
- out_valid, output, 1: the result is valid.
- out_ready, input, 1: downstream accepts the result.
- out_data, output, N: saturated signed Q-format sum.
- out_ovr, output, 1: sticky flag; set if any term had in_ovr or any addition saturated.
- out_err, output, 1: vector was force-terminated at MAXLEN without in_last.
- out_count, output, CW: number of terms accepted into this result.

## Operation
- Two states: ACC and HOLD. Reset state is ACC with the accumulator, flags and count cleared.
- ACC:
  - in_ready=1 and out_valid=0.
  - A term is accepted when in_valid && in_ready.
  - On accept: acc ← sat(acc + in_data); ovr ← ovr | in_ovr | sat_hit; count ← count+1.
  - Go to HOLD if in_last, or if count+1 == MAXLEN. In the second case, if in_last=0, set err.
- HOLD:
  - in_ready=0 and out_valid=1.
  - out_data, out_ovr, out_err and out_count are driven from registers and stay stable while out_ready=0.
  - On out_ready: go to ACC and clear acc, ovr, err and count in the same edge.
- Arithmetic:
  - The sum is formed at N+1 bits by sign-extending both operands.
  - If the top two bits differ, clamp: positive overflow → 2^(N-1)-1; negative overflow → -2^(N-1). Set sat_hit.
  - No rescaling is applied, because the Q point is already aligned by the multiplier.
- in_ovr only flags the result. The term value is added as received.
- in_data, in_ovr and in_last are ignored when the term is not accepted.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_ovr=0, out_err=0, out_count=0. Reset mid-vector discards the partial sum immediately, without waiting for a clock edge.
- Throughput: one term per cycle in ACC.
- Latency: out_valid rises on the edge that accepts the last term and is visible the following cycle.
- Bubble: one idle cycle after each output handshake. in_ready returns the cycle after out_valid && out_ready.
- A single-term vector (in_last on the first term) produces result = that term and count=1.
- If in_valid is held high during HOLD, the term is not consumed. The upstream must keep it stable until in_ready=1.
- Once saturated, the accumulator continues to add further terms to the clamped value. This lets a later opposite-sign term pull it back, and the ovr flag stays set.

## Test plan
- Basic sum, Q=18:
  - Stimulus: 0x00040000 (1.0), 0x00080000 (2.0), 0xFFFE0000 (-0.5, last).
  - Required response: out_data=0x000A0000 (2.5), count=3, ovr=0, err=0, out_valid one cycle after the last accept.
- Positive saturation:
  - Stimulus: 0x7FFF0000 + 0x7FFF0000 (last).
  - Required response: out_data=0x7FFFFFFF, out_ovr=1.
- Negative saturation:
  - Stimulus: 0x80010000 + 0x80010000 (last).
  - Required response: out_data=0x80000000, out_ovr=1.
- Multiplier overflow propagation:
  - Stimulus: term 1 with in_ovr=1, term 2 without; values 0x00040000 each.
  - Required response: out_data=0x00080000, out_ovr=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after a result, with in_valid held high.
  - Required response: outputs stable and in_ready=0 throughout. After out_ready=1, next vector's first term accepted one cycle later; its sum starts from 0.
- Length limit and reset:
  - Stimulus: with MAXLEN=8, send 9 terms of 0x00040000, none marked last.
  - Required response: result after the 8th term with out_data=0x00200000, count=8, err=1. The 9th term starts a new vector.
  - Stimulus: assert rst_n low mid-vector.
  - Required response: all outputs return to their reset values immediately.

Source files
------------

// File: rtl/qacc.sv
// Saturating signed fixed-point dot-product accumulator that sits after the Q-format multiplier.
// Sums one vector of product terms, then holds the result until downstream takes it.
module qacc #(
  parameter int Q      = 18,
  parameter int N      = 32,
  parameter int MAXLEN = 8,
  parameter int CW     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_ovr,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_ovr,
  output logic          out_err,
  output logic [CW-1:0] out_count,
  output logic [0:0]    dbg_state
);

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

  // Q only has to agree with the multiplier; the binary point is already aligned.
  if (Q >= N || Q < 0) begin : g_bad_q
    $error("qacc: Q must be in [0, N-1]");
  end
  if ((1 << CW) <= MAXLEN) begin : g_bad_cw
    $error("qacc: CW too narrow to hold MAXLEN");
  end

  logic [0:0]    state;
  logic [N-1:0]  acc;
  logic          ovr;
  logic          err;
  logic [CW-1:0] count;

  logic          in_fire;
  logic          out_fire;
  logic [N:0]    sum_wide;
  logic          sat_pos;
  logic          sat_neg;
  logic [N-1:0]  sum_sat;
  logic [CW-1:0] count_inc;
  logic          at_limit;

  // Handshake: a transfer happens on a rising edge where valid && ready; valid never
  // waits on ready, and ready here depends only on state, so no combinational loop.
  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_HOLD);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // One guard bit: the top two bits disagree exactly when the true sum left N-bit range.
  assign sum_wide = {acc[N-1], acc} + {in_data[N-1], in_data};
  assign sat_pos  = ~sum_wide[N] & sum_wide[N-1];
  assign sat_neg  = sum_wide[N] & ~sum_wide[N-1];

  always_comb begin
    sum_sat = sum_wide[N-1:0];
    if (sat_pos) begin
      sum_sat = SAT_MAX;
    end else if (sat_neg) begin
      sum_sat = SAT_MIN;
    end
  end

  assign count_inc = count + CW'(1);
  assign at_limit  = (count_inc == CW'(MAXLEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACC;
      acc   <= '0;
      ovr   <= 1'b0;
      err   <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        ST_ACC: begin
          if (in_fire) begin
            acc   <= sum_sat;
            ovr   <= ovr | in_ovr | sat_pos | sat_neg;
            count <= count_inc;
            if (in_last || at_limit) begin
              state <= ST_HOLD;
            end
            if (at_limit && !in_last) begin
              err <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (out_fire) begin
            state <= ST_ACC;
            acc   <= '0;
            ovr   <= 1'b0;
            err   <= 1'b0;
            count <= '0;
          end
        end
        default: begin
          state <= ST_ACC;
        end
      endcase
    end
  end

  assign out_data  = acc;
  assign out_ovr   = ovr;
  assign out_err   = err;
  assign out_count = count;
  assign dbg_state = state;

endmodule

// File: tb/tb_qacc.sv
// Directed bench for qacc: hand-computed dot-product results checked against an expected queue.
module tb_qacc;

  localparam int Q      = 18;
  localparam int N      = 32;
  localparam int MAXLEN = 8;
  localparam int CW     = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_ovr;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          out_ovr;
  logic          out_err;
  logic [CW-1:0] out_count;
  logic [0:0]    dbg_state;

  int total;
  int bad;

  logic [N-1:0] exp_q[$];

  qacc #(.Q(Q), .N(N), .MAXLEN(MAXLEN), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ovr    (in_ovr),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovr   (out_ovr),
    .out_err   (out_err),
    .out_count (out_count),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // driver: present one term at a negedge, hold it until accepted (bounded)
  task automatic send_term(input logic [N-1:0] data, input logic ovr, input logic last);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = data;
    in_ovr   = ovr;
    in_last  = last;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("send_accept_timeout", N'(in_ready), N'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_ovr   = 1'b0;
    in_last  = 1'b0;
  endtask

  // scoreboard side: wait for a result, compare against the queue and flags, then take it
  task automatic get_result(input string tag, input logic e_ovr, input logic e_err,
                            input logic [CW-1:0] e_cnt);
    int waited;
    logic [N-1:0] e_data;
    waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_valid"}, N'(out_valid), N'(1));
    e_data = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_data"}, out_data, e_data);
    check({tag, "_ovr"}, N'(out_ovr), N'(e_ovr));
    check({tag, "_err"}, N'(out_err), N'(e_err));
    check({tag, "_count"}, N'(out_count), N'(e_cnt));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [N-1:0] held;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ovr    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", N'(in_ready), N'(1));
    check("rst_out_valid", N'(out_valid), N'(0));
    check("rst_out_data", out_data, '0);
    check("rst_out_ovr", N'(out_ovr), N'(0));
    check("rst_out_err", N'(out_err), N'(0));
    check("rst_out_count", N'(out_count), N'(0));
    check("rst_state", N'(dbg_state), N'(0));
    rst_n = 1'b1;

    // basic sum: 1.0 + 2.0 - 0.5 = 2.5
    exp_q.push_back(32'h000A_0000);
    send_term(32'h0004_0000, 1'b0, 1'b0);
    send_term(32'h0008_0000, 1'b0, 1'b0);
    send_term(32'hFFFE_0000, 1'b0, 1'b1);
    @(negedge clk);
    check("basic_latency", N'(out_valid), N'(1));
    check("basic_in_ready_low", N'(in_ready), N'(0));
    get_result("basic", 1'b0, 1'b0, 4'd3);

    // positive saturation
    exp_q.push_back(32'h7FFF_FFFF);
    send_term(32'h7FFF_0000, 1'b0, 1'b0);
    send_term(32'h7FFF_0000, 1'b0, 1'b1);
    get_result("sat_pos", 1'b1, 1'b0, 4'd2);

    // negative saturation
    exp_q.push_back(32'h8000_0000);
    send_term(32'h8001_0000, 1'b0, 1'b0);
    send_term(32'h8001_0000, 1'b0, 1'b1);
    get_result("sat_neg", 1'b1, 1'b0, 4'd2);

    // clamp then pull back: 0x7FFFFFFF + 0x80000000 = -1, ovr stays set
    exp_q.push_back(32'hFFFF_FFFF);
    send_term(32'h7FFF_0000, 1'b0, 1'b0);
    send_term(32'h7FFF_0000, 1'b0, 1'b0);
    send_term(32'h8000_0000, 1'b0, 1'b1);
    get_result("pullback", 1'b1, 1'b0, 4'd3);

    // multiplier overflow only flags, value still added
    exp_q.push_back(32'h0008_0000);
    send_term(32'h0004_0000, 1'b1, 1'b0);
    send_term(32'h0004_0000, 1'b0, 1'b1);
    get_result("mul_ovr", 1'b1, 1'b0, 4'd2);

    // single-term vector
    exp_q.push_back(32'hFFF0_0000);
    send_term(32'hFFF0_0000, 1'b0, 1'b1);
    get_result("single", 1'b0, 1'b0, 4'd1);

    // backpressure: result held 5 cycles while the next term waits with in_valid high
    send_term(32'h0010_0000, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h0004_0000;
    in_last  = 1'b1;
    held     = 32'h0010_0000;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", N'(out_valid), N'(1));
      check("bp_in_ready", N'(in_ready), N'(0));
      check("bp_data", out_data, held);
      check("bp_count", N'(out_count), N'(1));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_ready_back", N'(in_ready), N'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_q.push_back(32'h0004_0000);
    get_result("bp_next", 1'b0, 1'b0, 4'd1);

    // length limit: 8 unmarked terms force a result with err set
    exp_q.push_back(32'h0020_0000);
    for (int i = 0; i < MAXLEN; i++) begin
      send_term(32'h0004_0000, 1'b0, 1'b0);
    end
    get_result("maxlen", 1'b0, 1'b1, 4'd8);
    // the 9th term opens a fresh vector
    exp_q.push_back(32'h0008_0000);
    send_term(32'h0004_0000, 1'b0, 1'b0);
    send_term(32'h0004_0000, 1'b0, 1'b1);
    get_result("after_max", 1'b0, 1'b0, 4'd2);

    // asynchronous reset mid-vector
    send_term(32'h0004_0000, 1'b1, 1'b0);
    send_term(32'h7FFF_0000, 1'b0, 1'b0);
    send_term(32'h7FFF_0000, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", N'(in_ready), N'(1));
    check("arst_out_valid", N'(out_valid), N'(0));
    check("arst_out_data", out_data, '0);
    check("arst_out_ovr", N'(out_ovr), N'(0));
    check("arst_out_count", N'(out_count), N'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'h0004_0000);
    send_term(32'h0004_0000, 1'b0, 1'b1);
    get_result("post_rst", 1'b0, 1'b0, 4'd1);

    check("exp_q_drained", N'(exp_q.size()), N'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
